// File: rtl/lab3_vector_gen.sv
// Clocked stimulus sweep for the Lab3 block: drives {a,b,c} through 000..111,
// captures {x,y} at the end of each hold and scores it against an expected table.
module lab3_vector_gen #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] exp_table_i,
    input  logic        x_i,
    input  logic        y_i,
    output logic        a_o,
    output logic        b_o,
    output logic        c_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] resp_o,
    output logic [3:0]  err_count_o,
    output logic        pass_o
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    resp_q, resp_d;
    logic [3:0]     err_q, err_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;

    function automatic logic slice_mismatch(input logic [15:0] tbl,
                                            input logic [2:0]  idx,
                                            input logic [1:0]  got);
        return (tbl[{idx, 1'b0} +: 2] != got);
    endfunction

    // Next-state and registered-output logic for the sweep FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_DRIVE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    resp_d  = 16'h0000;
                    err_d   = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_DRIVE: begin
                if (cnt_q == LAST_CNT) begin
                    resp_d[{idx_q, 1'b0} +: 2] = {x_i, y_i};
                    err_d = err_q + {3'd0, slice_mismatch(exp_table_i, idx_q, {x_i, y_i})};
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        // pass must see the increment from the final capture
                        state_d = S_DONE;
                        idx_d   = 3'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 4'd0);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
                cnt_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            resp_q  <= 16'h0000;
            err_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign a_o         = idx_q[2];
    assign b_o         = idx_q[1];
    assign c_o         = idx_q[0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign resp_o      = resp_q;
    assign err_count_o = err_q;
    assign pass_o      = pass_q;

endmodule

// File: tb/tb_lab3_vector_gen.sv
// Directed bench for lab3_vector_gen: a table of sweeps against a Lab3 model
// (x = a^b^c, y = majority) plus hand-written start/reset/HOLD=1 sequences.
module tb_lab3_vector_gen;

    typedef struct {
        logic [15:0] tbl;
        logic        inv_x;
        logic [15:0] resp;
        logic [3:0]  err;
        logic        pass;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start10 = 1'b0, start1 = 1'b0;
    logic [15:0] tbl10 = 16'h0000, tbl1 = 16'h0000;
    logic        inv_x = 1'b0;

    logic        a10, b10, c10, busy10, done10, pass10, x10, y10;
    logic [15:0] resp10;
    logic [3:0]  err10;
    logic        a1, b1, c1, busy1, done1, pass1, x1, y1;
    logic [15:0] resp1;
    logic [3:0]  err1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign x10 = a10 ^ b10 ^ c10 ^ inv_x;
    assign y10 = (a10 & b10) | (a10 & c10) | (b10 & c10);
    assign x1  = a1 ^ b1 ^ c1;
    assign y1  = (a1 & b1) | (a1 & c1) | (b1 & c1);

    lab3_vector_gen #(.HOLD_CYCLES(10)) dut10 (
        .clk_i(clk), .rst_i(rst), .start_i(start10), .exp_table_i(tbl10),
        .x_i(x10), .y_i(y10), .a_o(a10), .b_o(b10), .c_o(c10),
        .busy_o(busy10), .done_o(done10), .resp_o(resp10),
        .err_count_o(err10), .pass_o(pass10)
    );

    lab3_vector_gen #(.HOLD_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .exp_table_i(tbl1),
        .x_i(x1), .y_i(y1), .a_o(a1), .b_o(b1), .c_o(c1),
        .busy_o(busy1), .done_o(done1), .resp_o(resp1),
        .err_count_o(err1), .pass_o(pass1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle10(input string tag);
        check({tag, " abc"},  {13'd0, a10, b10, c10}, 16'd0);
        check({tag, " busy"}, {15'd0, busy10}, 16'd0);
        check({tag, " done"}, {15'd0, done10}, 16'd0);
        check({tag, " pass"}, {15'd0, pass10}, 16'd0);
        check({tag, " resp"}, resp10, 16'h0000);
        check({tag, " err"},  {12'd0, err10}, 16'd0);
    endtask

    // One HOLD=10 sweep; extra start pulse at cycle mid_start (negative = none)
    task automatic sweep10(input vec_t v, input int mid_start);
        tbl10 = v.tbl;
        inv_x = v.inv_x;
        start10 = 1'b1;
        tick();
        start10 = 1'b0;
        check("start busy", {15'd0, busy10}, 16'd1);
        check("start done", {15'd0, done10}, 16'd0);
        check("start abc",  {13'd0, a10, b10, c10}, 16'd0);
        check("start resp", resp10, 16'h0000);
        check("start err",  {12'd0, err10}, 16'd0);
        for (int k = 1; k <= 80; k++) begin
            if (k == mid_start) start10 = 1'b1;
            tick();
            start10 = 1'b0;
            if (k < 80) begin
                check("sweep busy", {15'd0, busy10}, 16'd1);
                check("sweep done", {15'd0, done10}, 16'd0);
                check("sweep abc",  {13'd0, a10, b10, c10}, 16'(k / 10));
            end
        end
        check("end busy", {15'd0, busy10}, 16'd0);
        check("end done", {15'd0, done10}, 16'd1);
        check("end abc",  {13'd0, a10, b10, c10}, 16'd0);
        check("end resp", resp10, v.resp);
        check("end err",  {12'd0, err10}, {12'd0, v.err});
        check("end pass", {15'd0, pass10}, {15'd0, v.pass});
        tick();
        check("hold done", {15'd0, done10}, 16'd1);
        check("hold resp", resp10, v.resp);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t good;
        int   busy_cycles;

        vecs[0] = '{16'hD668, 1'b0, 16'hD668, 4'd0, 1'b1};
        vecs[1] = '{16'hD669, 1'b0, 16'hD668, 4'd1, 1'b0};
        vecs[2] = '{16'h0000, 1'b0, 16'hD668, 4'd7, 1'b0};
        vecs[3] = '{16'hD668, 1'b1, 16'h7CC2, 4'd8, 1'b0};
        vecs[4] = '{16'h7CC2, 1'b1, 16'h7CC2, 4'd0, 1'b1};
        good    = vecs[0];

        // Reset values and no activity without start
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_idle10("reset");
        repeat (5) tick();
        check_idle10("idle");
        check("reset dut1 busy", {15'd0, busy1}, 16'd0);

        // Table of full sweeps, each started from DONE of the previous one
        for (int i = 0; i < 5; i++) sweep10(vecs[i], -1);

        // start pulsed at cycle 25 of a sweep is ignored
        sweep10(good, 25);

        // Reset mid-sweep while {a,b,c}=011
        tbl10 = 16'hD668;
        inv_x = 1'b0;
        start10 = 1'b1;
        tick();
        start10 = 1'b0;
        repeat (35) tick();
        check("pre-rst abc", {13'd0, a10, b10, c10}, 16'd3);
        #2;
        rst = 1'b1;
        #1;
        check_idle10("async rst");
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check_idle10("post rst");
        sweep10(good, -1);

        // start coincident with rst: reset wins
        start10 = 1'b1;
        rst = 1'b1;
        tick();
        start10 = 1'b0;
        rst = 1'b0;
        tick();
        check_idle10("start+rst");

        // HOLD_CYCLES = 1
        tbl1 = 16'hD668;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        busy_cycles = 0;
        check("h1 start abc", {13'd0, a1, b1, c1}, 16'd0);
        for (int k = 1; k <= 12; k++) begin
            if (busy1) busy_cycles++;
            tick();
            if (k < 8) check("h1 abc", {13'd0, a1, b1, c1}, 16'(k));
        end
        check("h1 busy cycles", 16'(busy_cycles), 16'd8);
        check("h1 done", {15'd0, done1}, 16'd1);
        check("h1 resp", resp1, 16'hD668);
        check("h1 err",  {12'd0, err1}, 16'd0);
        check("h1 pass", {15'd0, pass1}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lab3_vector_gen.md
# lab3_vector_gen

Self-checking stimulus sequencer placed directly upstream of the Lab3 combinational block. Drives Lab3 inputs `a`, `b`, `c` through all eight combinations 000→111, holding each for a fixed number of cycles. On the last cycle of each hold, it captures the returned `x`, `y` and compares them against an expected truth table. It reports the captured response word, a mismatch count and a pass flag, replacing hand-timed stimulus with a clocked, repeatable sweep.

## Interface
- `HOLD_CYCLES`, default 10: cycles each input vector is held. Must be ≥1.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a sweep. Accepted in IDLE or DONE, ignored while busy.
- `exp_table`  in  16  expected responses; slice [2i+1:2i] = {x,y} expected for vector i = {a,b,c}.
- `x`, `y`  in  1 each  Lab3 outputs, combinational from `a`, `b`, `c`.
- `a`, `b`, `c`  out  1 each  Lab3 inputs; {a,b,c} = current vector index.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished. Level signal, held until the next accepted start or reset.
- `resp`  out  16  captured {x,y} per vector, same packing as `exp_table`.
- `err_count`  out  4  number of mismatching vectors, 0..8.
- `pass`  out  1  high in DONE when err_count == 0.

## Operation
- Every output is registered. Reset value of every output is 0.
- FSM states: IDLE, DRIVE, DONE.
- **IDLE** (after reset):
  - start=1 → DRIVE.
  - On that edge: idx=0, hold count=0, resp=0, err_count=0, done=0, pass=0, busy=1.
- **DRIVE**:
  - {a,b,c} = idx. Count increments every cycle.
  - At the edge where count == HOLD_CYCLES-1:
    - resp[2*idx+1:2*idx] ← {x,y}.
    - If {x,y} ≠ exp_table slice, err_count increments.
    - If idx < 7: idx increments, count ← 0.
    - If idx == 7: → DONE.
  - `start` is ignored in DRIVE.
- **DONE**:
  - busy=0, done=1, {a,b,c}=000 (idx cleared).
  - pass = (final err_count == 0), including the increment from the last vector.
  - resp and err_count hold their values.
  - start=1 → DRIVE, with the same clearing as from IDLE.
- `exp_table` is sampled live at each capture edge. The bench holds it stable for the whole sweep.
- Hold counter width: $clog2(HOLD_CYCLES+1). No wrap occurs because the counter resets to 0 at each vector change.
- err_count saturation is not needed; the maximum is 8, which fits in 4 bits.

## Timing
- **Start latency:** start high at edge E0 → busy=1 and {a,b,c}=000 visible after E0.
- **Vector schedule:** vector i is driven from E0 + i·HOLD_CYCLES to E0 + (i+1)·HOLD_CYCLES. Capture happens at the closing edge of each hold, so Lab3 has HOLD_CYCLES−1 full cycles plus one to settle.
- **Sweep length:** busy is high for exactly 8·HOLD_CYCLES cycles. done rises at edge E0 + 8·HOLD_CYCLES, in the same edge as the vector-7 capture.
- **HOLD_CYCLES = 1:** vector advances every cycle; capture occurs every cycle.
- **Reset mid-sweep:** asynchronous return to IDLE; all outputs 0 immediately. A new start is required.
- **start coincident with rst:** reset wins.

## Test plan
- **Reset values:** assert rst for 3 cycles, then release → a,b,c,busy,done,pass = 0; resp = 0x0000; err_count = 0; no activity without start.
- **Full pass, HOLD=10:**
  - Stimulus: Lab3 model x = a^b^c, y = majority(a,b,c); exp_table = 0xD668; pulse start.
  - Required: {a,b,c} steps 0..7, each held 10 cycles.
  - Required after 80 cycles: done=1, busy=0, resp=0xD668, err_count=0, pass=1.
- **Single mismatch:** same model, exp_table = 0xD669 → after 80 cycles: resp=0xD668, err_count=1, pass=0.
- **start handling:**
  - Pulse start at cycle 25 of a sweep → ignored; done still arrives at cycle 80.
  - Pulse start in DONE → done falls, resp and err_count clear, new 80-cycle sweep runs.
- **Reset mid-sweep:** assert rst while {a,b,c}=011 → all outputs 0 immediately. Stay IDLE until the next start; the next sweep completes with resp=0xD668.
- **HOLD_CYCLES=1:** {a,b,c} changes every cycle; busy high for exactly 8 cycles; resp=0xD668, pass=1.
